// File: rtl/intr_pkg.sv
// Shared definitions for the parameterised interrupt controller: one-hot FSM
// encodings and register-map offsets relative to N_INTR.
package intr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ARB   = 3'b010,
    SERVE = 3'b100
  } intr_state_e;

  localparam int ENABLE_OFS = 0;
  localparam int EDGE_OFS   = 1;
  localparam int PEND_OFS   = 2;

endpackage

// File: rtl/intr_prio_arb.sv
// Combinational priority arbiter: highest PRIO value wins among eligible
// sources, ties resolved toward the lowest id.
module intr_prio_arb #(
  parameter int N_INTR = 16,
  parameter int PRIO_W = 4
) (
  input  logic [N_INTR-1:0]        eligible,
  input  logic [N_INTR*PRIO_W-1:0] prio_flat,
  output logic [$clog2(N_INTR)-1:0] win_id,
  output logic                     any_valid
);

  localparam int ID_W = $clog2(N_INTR);

  logic [PRIO_W-1:0] best_prio;

  // Strict '>' keeps the earlier (lower) id on equal priority.
  always_comb begin
    win_id    = '0;
    any_valid = 1'b0;
    best_prio = '0;
    for (int i = 0; i < N_INTR; i++) begin
      if (eligible[i] && (!any_valid || (prio_flat[i*PRIO_W +: PRIO_W] > best_prio))) begin
        win_id    = ID_W'(i);
        any_valid = 1'b1;
        best_prio = prio_flat[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/intr_ctrl_param.sv
// APB-programmable interrupt controller: per-source priority, enable and
// level/edge mode, with an IDLE/ARB/SERVE handshake toward a service agent.
module intr_ctrl_param
  import intr_pkg::*;
#(
  parameter int N_INTR = 16,
  parameter int PRIO_W = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                      pclk,
  input  logic                      prst_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_W-1:0]         paddr,
  input  logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W-1:0]         prdata,
  output logic                      pready,
  output logic                      pslverr,
  input  logic [N_INTR-1:0]         intr_active,
  output logic [$clog2(N_INTR)-1:0] intr_to_service,
  output logic                      intr_valid,
  input  logic                      intr_serviced
);

  localparam int ID_W        = $clog2(N_INTR);
  localparam int ENABLE_ADDR = N_INTR + ENABLE_OFS;
  localparam int EDGE_ADDR   = N_INTR + EDGE_OFS;
  localparam int PEND_ADDR   = N_INTR + PEND_OFS;
  localparam int N_REGS      = PEND_ADDR + 1;

  logic [PRIO_W-1:0]        prio_q [N_INTR];
  logic [N_INTR*PRIO_W-1:0] prio_flat;
  logic [N_INTR-1:0]        enable_q, edge_q, edge_pend_q, prev_q;
  logic [N_INTR-1:0]        pending, eligible, rise, w1c, svc_mask, edge_pend_d;
  logic [DATA_W-1:0]        rd_data;
  logic [ID_W-1:0]          win_id, id_q;
  logic                     any_valid, valid_q, addr_ok, wr_en, svc_done;
  logic                     unused_bits;
  intr_state_e              state_q;
  int                       addr_i;

  assign addr_i  = int'(paddr);
  assign addr_ok = (addr_i < N_REGS);
  assign wr_en   = psel & penable & pwrite & addr_ok;
  assign pready  = prst_n & psel & penable;
  assign pslverr = pready & ~addr_ok;
  assign unused_bits = ^pwdata;

  assign pending  = (edge_q & edge_pend_q) | (~edge_q & intr_active);
  assign eligible = pending & enable_q;

  // Edge pending: set beats clear when both land on the same bit.
  assign svc_done    = (state_q == SERVE) & intr_serviced;
  assign svc_mask    = svc_done ? (N_INTR'(1) << id_q) : '0;
  assign w1c         = (wr_en && addr_i == PEND_ADDR) ? pwdata[N_INTR-1:0] : '0;
  assign rise        = intr_active & ~prev_q & edge_q;
  assign edge_pend_d = (edge_pend_q & ~(w1c | svc_mask)) | rise;

  always_comb begin
    prio_flat = '0;
    for (int i = 0; i < N_INTR; i++) prio_flat[i*PRIO_W +: PRIO_W] = prio_q[i];
  end

  always_comb begin
    rd_data = '0;
    if (addr_i == ENABLE_ADDR)    rd_data[N_INTR-1:0] = enable_q;
    else if (addr_i == EDGE_ADDR) rd_data[N_INTR-1:0] = edge_q;
    else if (addr_i == PEND_ADDR) rd_data[N_INTR-1:0] = pending;
    else begin
      for (int i = 0; i < N_INTR; i++)
        if (addr_i == i) rd_data[PRIO_W-1:0] = prio_q[i];
    end
  end

  assign prdata = (prst_n && psel && !pwrite && addr_ok) ? rd_data : '0;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int i = 0; i < N_INTR; i++) prio_q[i] <= '0;
      enable_q    <= '1;
      edge_q      <= '0;
      edge_pend_q <= '0;
      prev_q      <= '0;
    end else begin
      prev_q      <= intr_active;
      edge_pend_q <= edge_pend_d;
      if (wr_en) begin
        for (int i = 0; i < N_INTR; i++)
          if (addr_i == i) prio_q[i] <= pwdata[PRIO_W-1:0];
        if (addr_i == ENABLE_ADDR) enable_q <= pwdata[N_INTR-1:0];
        if (addr_i == EDGE_ADDR)   edge_q   <= pwdata[N_INTR-1:0];
      end
    end
  end

  intr_prio_arb #(.N_INTR(N_INTR), .PRIO_W(PRIO_W)) u_arb (
    .eligible  (eligible),
    .prio_flat (prio_flat),
    .win_id    (win_id),
    .any_valid (any_valid)
  );

  // If the request vanished between IDLE and ARB, fall back to IDLE.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|eligible) state_q <= ARB;
        ARB: begin
          if (any_valid) begin
            id_q    <= win_id;
            valid_q <= 1'b1;
            state_q <= SERVE;
          end else begin
            state_q <= IDLE;
          end
        end
        SERVE: begin
          if (intr_serviced) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign intr_to_service = id_q;
  assign intr_valid      = valid_q;

endmodule
